pc_branch_unit: RTL and testbench
=================================

Name: pc_branch_unit

Overview:
Program-counter sequencer and the consumer end of the branch-offset lookup path.
- Holds an 8-entry, software-writable table of signed branch offsets, reset to the standard offset set.
- Advances the PC each cycle: sequential +1, relative branch by a table offset, or halt.
- Provides the start/done handshake to the testbench/top level.
- Drives instruction-ROM address prog_ctr.

Parameters:
D, 12, PC and offset width (bits); all PC arithmetic is modulo 2**D
N, 8, number of branch-target table entries
IW, 3, table index width (log2 N)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse: begin/restart program at address 0
halt_req  input  1  decoder's done/halt instruction seen this cycle
branch_en  input  1  taken-branch this cycle
how_high  input  IW  branch table index
tbl_we  input  1  table write enable (writer port)
tbl_waddr  input  IW  table write index
tbl_wdata  input  D  table write data (two's-complement offset)
prog_ctr  output  D  current PC (instruction address)
running  output  1  high while in RUN
done  output  1  high while in HALT

Behaviour:
Clock and reset:
- Single clock clk; reset is asynchronous, active-high.
- On reset assertion, immediately (no clock needed): state=IDLE, prog_ctr=0, running=0, done=0.
- Also on reset, the table reloads defaults: {0:2, 1:4, 2:22, 3:-26, 4:130, 5:-132, 6:162, 7:-168}, stored D-bit two's complement (e.g. -26 = 0xFE6).

States IDLE, RUN, HALT; all outputs registered or decoded from state:
- IDLE: prog_ctr holds 0. start=1 -> RUN at next edge, prog_ctr stays 0 (first fetch at 0).
- RUN, checked in priority order each edge:
  - halt_req=1 -> HALT, prog_ctr holds.
  - else branch_en=1 -> prog_ctr <= (prog_ctr + table[how_high]) mod 2**D.
  - else prog_ctr <= prog_ctr + 1 mod 2**D.
- RUN: start is ignored.
- HALT: prog_ctr holds, done=1. start=1 -> RUN, prog_ctr <= 0, done=0 at the same edge.

Arithmetic:
- D-bit add with carry-out discarded. No sign extension is needed since offsets are stored at width D.
- 0xFFF+1=0x000; 0x002+0xFE6=0xFE8.

Table:
- Asynchronous read; synchronous write on tbl_we at the clock edge.
- Writes are accepted in every state.
- Same-cycle write and branch read of the same index: the branch uses the old value; the new value is visible from the next cycle.

Simultaneous events:
- halt_req and branch_en together -> halt wins.
- start and halt_req together in RUN -> halt wins.
- halt_req outside RUN and branch_en outside RUN are ignored.

Latency: one cycle from control inputs to updated prog_ctr/running/done.

Optional Feature:
PC_BR_COUNT_EN
- Defined: adds output br_count [15:0], counting taken branches in RUN. Increments only when branch_en=1 and halt_req=0. Saturates at 0xFFFF. Cleared by reset and by an accepted start.
- Undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
Package pc_pkg:
- D and N constants.
- State enum typedef {IDLE, RUN, HALT}.
- Offset typedef logic [D-1:0].
- Default table constant array BR_DEFAULTS[N].

Natural sub-module branch_target_table:
- N x D register file with async read, sync write, async reset to BR_DEFAULTS.
- Instantiated once; the FSM and PC adder stay in pc_branch_unit.

Test Plan:
1. Reset, then start, then 3 idle cycles: PC 0 then 1,2,3; running=1, done=0; prior to start PC=0, running=0.
2. At PC=5, branch_en=1, how_high=3: next PC = 0xFEB (5-26 mod 4096); at PC=0xFEB, how_high=6: next PC = 0x08D (mod wrap).
3. Write entry 0 = 0xFFE; at PC=1 branch idx0: PC 0xFFF; next sequential cycle: PC 0x000.
4. At PC=10, tbl_we idx2=100 and branch idx2 in the same cycle: PC=32 (old 22); at PC=32, branch idx2: PC=132.
5. At PC=7, halt_req=1 and branch_en=1: PC stays 7, done=1, running=0; start one cycle later: PC 0, done=0, running=1.
6. Overwrite entry 4 = 1, run to PC=40, assert reset mid-cycle: immediately PC 0, IDLE, done=0; entry 4 reads 130 again (branch idx4 at PC 0 after start gives PC 130).

Source files
------------

// File: rtl/pc_branch_unit_pkg.sv
// ============================================================================
// Module : pc_pkg
// Brief  : Shared constants, state encoding and reset offset table for the
//          PC sequencer / branch-target table.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_pkg;

   localparam int D  = 12;
   localparam int N  = 8;
   localparam int IW = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   typedef logic [D-1:0] offset_t;

   // Signed offsets held as D-bit two's complement: 2,4,22,-26,130,-132,162,-168
   localparam offset_t BR_DEFAULTS [N] = '{
      12'h002, 12'h004, 12'h016, 12'hFE6,
      12'h082, 12'hF7C, 12'h0A2, 12'hF58
   };

endpackage

`default_nettype wire

// File: rtl/pc_branch_unit_table.sv
// ============================================================================
// Module : branch_target_table
// Brief  : N x D offset register file, async read, sync write, async reset
//          to the default offset set.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_target_table
   import pc_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_we,
   input  logic [IW-1:0] i_waddr,
   input  offset_t       i_wdata,
   input  logic [IW-1:0] i_raddr,
   output offset_t       o_rdata
);

   offset_t r_tbl [N];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            r_tbl[i] <= BR_DEFAULTS[i];
         end
      end else if (i_we) begin
         r_tbl[i_waddr] <= i_wdata;
      end
   end

   // Read sees the pre-edge contents, so a same-cycle write is not forwarded.
   assign o_rdata = r_tbl[i_raddr];

endmodule

`default_nettype wire

// File: rtl/pc_branch_unit.sv
// ============================================================================
// Module : pc_branch_unit
// Brief  : PC sequencer (IDLE/RUN/HALT) with relative branches through a
//          writable offset table. Optional taken-branch counter via
//          `define PC_BR_COUNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_branch_unit
   import pc_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          halt_req,
   input  logic          branch_en,
   input  logic [IW-1:0] how_high,
   input  logic          tbl_we,
   input  logic [IW-1:0] tbl_waddr,
   input  logic [D-1:0]  tbl_wdata,
   output logic [D-1:0]  prog_ctr,
   output logic          running,
   output logic          done
`ifdef PC_BR_COUNT_EN
   ,
   output logic [15:0]   br_count
`endif
);

   state_t       r_state;
   logic [D-1:0] r_pc;
   logic         r_running;
   logic         r_done;
   offset_t      w_off;

   branch_target_table u_table (
      .clk     (clk),
      .rst     (reset),
      .i_we    (tbl_we),
      .i_waddr (tbl_waddr),
      .i_wdata (tbl_wdata),
      .i_raddr (how_high),
      .o_rdata (w_off)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_pc      <= '0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_pc <= '0;
               if (start) begin
                  r_state   <= RUN;
                  r_running <= 1'b1;
               end
            end
            RUN: begin
               // Halt outranks branch and sequential advance; start is ignored.
               if (halt_req) begin
                  r_state   <= HALT;
                  r_running <= 1'b0;
                  r_done    <= 1'b1;
               end else if (branch_en) begin
                  r_pc <= r_pc + w_off;
               end else begin
                  r_pc <= r_pc + 1'b1;
               end
            end
            HALT: begin
               if (start) begin
                  r_state   <= RUN;
                  r_pc      <= '0;
                  r_running <= 1'b1;
                  r_done    <= 1'b0;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_pc      <= '0;
               r_running <= 1'b0;
               r_done    <= 1'b0;
            end
         endcase
      end
   end

   assign prog_ctr = r_pc;
   assign running  = r_running;
   assign done     = r_done;

`ifdef PC_BR_COUNT_EN
   logic [15:0] r_br_count;
   logic        w_start_acc;
   logic        w_br_taken;

   assign w_start_acc = start && (r_state != RUN);
   assign w_br_taken  = (r_state == RUN) && branch_en && !halt_req;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_br_count <= '0;
      end else if (w_start_acc) begin
         r_br_count <= '0;
      end else if (w_br_taken && (r_br_count != 16'hFFFF)) begin
         r_br_count <= r_br_count + 16'd1;
      end
   end

   assign br_count = r_br_count;
`else
   // Counter and port are absent in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
// ============================================================================
// Module : tb_pc_branch_unit
// Brief  : Directed scoreboard bench for pc_branch_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_branch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        halt_req = 1'b0;
   logic        branch_en = 1'b0;
   logic [2:0]  how_high = 3'd0;
   logic        tbl_we = 1'b0;
   logic [2:0]  tbl_waddr = 3'd0;
   logic [11:0] tbl_wdata = 12'd0;
   logic [11:0] prog_ctr;
   logic        running;
   logic        done;
`ifdef PC_BR_COUNT_EN
   logic [15:0] br_count;
`endif

   pc_branch_unit dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .halt_req  (halt_req),
      .branch_en (branch_en),
      .how_high  (how_high),
      .tbl_we    (tbl_we),
      .tbl_waddr (tbl_waddr),
      .tbl_wdata (tbl_wdata),
      .prog_ctr  (prog_ctr),
      .running   (running),
      .done      (done)
`ifdef PC_BR_COUNT_EN
      ,
      .br_count  (br_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] pc;
      logic        run;
      logic        dn;
      string       tag;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic push(input logic [11:0] pc, input logic r, input logic d, input string tag);
      exp_t e;
      e.pc = pc; e.run = r; e.dn = d; e.tag = tag;
      q.push_back(e);
   endtask

   // Drive one cycle of inputs, then queue the state expected after the edge.
   task automatic cyc(input logic st, input logic hr, input logic be, input logic [2:0] hh,
                      input logic we, input logic [2:0] wa, input logic [11:0] wd,
                      input logic [11:0] epc, input logic er, input logic ed, input string tag);
      start = st; halt_req = hr; branch_en = be; how_high = hh;
      tbl_we = we; tbl_waddr = wa; tbl_wdata = wd;
      @(posedge clk); #1;
      push(epc, er, ed, tag);
      start = 1'b0; halt_req = 1'b0; branch_en = 1'b0; how_high = 3'd0;
      tbl_we = 1'b0; tbl_waddr = 3'd0; tbl_wdata = 12'd0;
   endtask

   task automatic seq(input logic [11:0] epc, input string tag);
      cyc(0, 0, 0, 3'd0, 0, 3'd0, 12'd0, epc, 1'b1, 1'b0, tag);
   endtask

   task automatic br(input logic [2:0] idx, input logic [11:0] epc, input string tag);
      cyc(0, 0, 1, idx, 0, 3'd0, 12'd0, epc, 1'b1, 1'b0, tag);
   endtask

   // Monitor: outputs are always presented; compare one queued entry per low phase.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({prog_ctr, running, done} !== {e.pc, e.run, e.dn}) begin
               errors++;
               $display("FAIL %s: got pc=%h running=%b done=%b, want pc=%h running=%b done=%b",
                        e.tag, prog_ctr, running, done, e.pc, e.run, e.dn);
            end
         end
      end
   end

   initial begin
      // Reset state while reset is held.
      @(posedge clk); #1;
      push(12'h000, 1'b0, 1'b0, "reset_state");
      @(negedge clk); #1;
      reset = 1'b0;

      // 1: idle before start, then start and sequential fetch
      cyc(0, 0, 0, 3'd0, 0, 3'd0, 12'd0, 12'h000, 1'b0, 1'b0, "idle_pre_start");
      cyc(0, 1, 1, 3'd3, 0, 3'd0, 12'd0, 12'h000, 1'b0, 1'b0, "idle_ignores_halt_br");
      cyc(1, 0, 0, 3'd0, 0, 3'd0, 12'd0, 12'h000, 1'b1, 1'b0, "start_pc0");
      seq(12'h001, "seq1");
      seq(12'h002, "seq2");
      seq(12'h003, "seq3");
      seq(12'h004, "seq4");
      seq(12'h005, "seq5");

      // 2: negative offset, then wrap-around forward
      br(3'd3, 12'hFEB, "br_idx3_neg");
      br(3'd6, 12'h08D, "br_idx6_wrap");

      // 3: halt with a table write, restart, branch to 0xFFF and wrap to 0
      cyc(0, 1, 0, 3'd0, 1, 3'd0, 12'hFFE, 12'h08D, 1'b0, 1'b1, "halt_with_write");
      cyc(0, 0, 1, 3'd0, 0, 3'd0, 12'd0, 12'h08D, 1'b0, 1'b1, "halt_ignores_br");
      cyc(1, 0, 0, 3'd0, 0, 3'd0, 12'd0, 12'h000, 1'b1, 1'b0, "restart_from_halt");
      seq(12'h001, "seq1b");
      br(3'd0, 12'hFFF, "br_idx0_written");
      seq(12'h000, "seq_wrap");

      // 4: same-cycle write and branch uses old entry
      for (int p = 1; p <= 10; p++) seq(12'(p), "seq_to10");
      cyc(0, 0, 1, 3'd2, 1, 3'd2, 12'd100, 12'd32, 1'b1, 1'b0, "br_old_value");
      br(3'd2, 12'd132, "br_new_value");

      // 5: halt beats branch; start in RUN ignored; start beats nothing in RUN
      cyc(0, 1, 0, 3'd0, 0, 3'd0, 12'd0, 12'd132, 1'b0, 1'b1, "halt_132");
      cyc(1, 0, 0, 3'd0, 0, 3'd0, 12'd0, 12'd0, 1'b1, 1'b0, "restart2");
      for (int p = 1; p <= 7; p++) seq(12'(p), "seq_to7");
      cyc(0, 1, 1, 3'd4, 0, 3'd0, 12'd0, 12'd7, 1'b0, 1'b1, "halt_beats_branch");
      cyc(1, 0, 0, 3'd0, 0, 3'd0, 12'd0, 12'd0, 1'b1, 1'b0, "restart3");
      cyc(1, 0, 0, 3'd0, 0, 3'd0, 12'd0, 12'd1, 1'b1, 1'b0, "start_ignored_in_run");

      // 6: overwrite entry 4, verify it, run to 40, async reset restores defaults
      cyc(0, 0, 0, 3'd0, 1, 3'd4, 12'd1, 12'd2, 1'b1, 1'b0, "write_idx4");
      br(3'd4, 12'd3, "br_idx4_is1");
      for (int p = 4; p <= 40; p++) seq(12'(p), "seq_to40");
      @(negedge clk); #1;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      push(12'h000, 1'b0, 1'b0, "async_reset");
      @(negedge clk); #1;
      cyc(0, 0, 0, 3'd0, 0, 3'd0, 12'd0, 12'd0, 1'b0, 1'b0, "idle_after_reset");
      cyc(1, 0, 0, 3'd0, 0, 3'd0, 12'd0, 12'd0, 1'b1, 1'b0, "start_after_reset");
      br(3'd4, 12'd130, "br_idx4_default");
      br(3'd5, 12'hFFE, "br_idx5_neg");
      cyc(1, 1, 0, 3'd0, 0, 3'd0, 12'd0, 12'hFFE, 1'b0, 1'b1, "halt_beats_start");

      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending entries, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
